alu_muldiv: RTL
===============

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two >= 8.
REQ-002 Parameter STEP, default 1, iteration bits per clock; SHALL be 1, 2 or 4 and divide XLEN.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 funct3  input  3  RV M-ext op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 rs1  input  XLEN  operand A / dividend.
REQ-009 rs2  input  XLEN  operand B / divisor.
REQ-010 out_valid  output  1  rd valid.
REQ-011 out_ready  input  1  consumer accepts rd.
REQ-012 rd  output  XLEN  result.
REQ-013 z  output  1  registered flag, 1 iff rd == 0 while out_valid.

Function
REQ-014 States IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept edge = rising edge with in_valid & in_ready; funct3/rs1/rs2 SHALL be captured there; later input changes have no effect.
REQ-016 Normal path: IDLE->CALC on accept; CALC performs STEP bits per edge for XLEN/STEP edges, then ->DONE; out_valid SHALL rise exactly XLEN/STEP edges after the accept edge.
REQ-017 Fast path: divide ops with rs2 == 0, or DIV/REM with rs1 == most-negative and rs2 == all-ones, SHALL go IDLE->DONE on the accept edge (out_valid one edge after accept).
REQ-018 Divide by zero: DIV/DIVU rd = all-ones; REM/REMU rd = rs1.
REQ-019 Signed overflow: DIV rd = rs1 (most-negative); REM rd = 0.
REQ-020 MUL SHALL return low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU high XLEN bits with rs1/rs2 signed/signed, signed/unsigned, unsigned/unsigned.
REQ-021 DIV/REM SHALL truncate toward zero; remainder sign follows dividend.
REQ-022 Signed ops SHALL run on magnitudes with sign fix-up on the final edge, within the REQ-016 latency.
REQ-023 DONE: rd, z, out_valid SHALL hold stable until the edge with out_ready=1, then ->IDLE, out_valid=0.
REQ-024 out_ready asserted in IDLE/CALC SHALL be ignored; no new accept in the DONE->IDLE edge (one idle cycle minimum between results).
REQ-025 Iteration counter SHALL be clog2(XLEN/STEP)+1 bits and SHALL not wrap.

Reset
REQ-026 rst SHALL force IDLE, out_valid=0, rd=0, z=0, counter=0, internal accumulators=0, immediately and regardless of clk.
REQ-027 rst during CALC or DONE SHALL discard the operation; no result produced after release.
REQ-028 First accept possible on the first rising edge after rst deasserts (in_ready=1 during that cycle).

Structure
REQ-029 Package riscy_pkg SHALL hold the funct3 op enum (muldiv_op_e) and the state enum (muldiv_state_e).
REQ-030 One combinational sub-module muldiv_step SHALL implement one radix-2 shift-add / restoring-subtract bit step; alu_muldiv SHALL chain STEP instances.

Verification (XLEN=32, STEP=1 unless noted)
REQ-031 MUL 20*30 -> rd=600, z=0, out_valid exactly 32 edges after accept; STEP=4 -> 8 edges.
REQ-032 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 8/3 -> 2; REMU 8/3 -> 2.
REQ-034 DIVU 8/0 -> 0xFFFFFFFF and REM 8/0 -> 8, both one edge after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0 with z=1.
REQ-035 out_ready low 5 cycles after out_valid -> rd/z stable, in_ready=0; out_ready high -> IDLE next edge, next request accepted one edge later.
REQ-036 rst pulse 10 edges into CALC -> out_valid=0, rd=0 immediately; in_ready=1 after release; no stale result ever appears.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit: funct3 op codes,
// FSM states and operand-signedness helpers.
package riscy_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_e;

  function automatic logic op_signed_a(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 bit step, purely combinational: shift-add for multiply
// (LSB-first on {hi,lo}) or restoring subtract for divide (MSB-first on {hi,lo}).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b} : '0);
    rem_sh = {hi_i, lo_i[XLEN-1]};
    ge     = rem_sh >= {1'b0, b};
    // When ge holds the true difference is below b, so XLEN bits suffice.
    diff   = rem_sh[XLEN-1:0] - b;
    if (is_div) begin
      hi_o = ge ? diff : rem_sh[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV M-extension unit: XLEN/STEP edges per op, 0 extra for div-by-zero/overflow.
// Single request in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_muldiv
  import riscy_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            z
);

  localparam int NITER = XLEN / STEP;
  localparam int CW    = $clog2(NITER) + 1;
  localparam logic [CW-1:0]   LAST    = CW'(NITER - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d, op_in;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            z_q, z_d;

  logic [XLEN-1:0]   hi_c [STEP+1];
  logic [XLEN-1:0]   lo_c [STEP+1];
  logic              sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res, res;
  logic [2*XLEN-1:0] prod_fix;

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < STEP; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (op_q[2]),
      .b      (b_q),
      .hi_i   (hi_c[g]),
      .lo_i   (lo_c[g]),
      .hi_o   (hi_c[g+1]),
      .lo_o   (lo_c[g+1])
    );
  end

  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    sa       = op_signed_a(op_in) & rs1[XLEN-1];
    sb       = op_signed_b(op_in) & rs2[XLEN-1];
    a_mag    = sa ? -rs1 : rs1;
    b_mag    = sb ? -rs2 : rs2;
    div_zero = op_in[2] && (rs2 == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (rs1 == MOST_NEG) && (rs2 == '1);
    // Divide-by-zero and overflow results are known at accept; bit1 selects REM/REMU.
    if (div_zero) fast_res = op_in[1] ? rs1 : '1;
    else          fast_res = op_in[1] ? '0 : rs1;

    // Sign fix-up on the final step's outputs, applied in the same edge.
    prod_fix = neg_q ? -{hi_c[STEP], lo_c[STEP]} : {hi_c[STEP], lo_c[STEP]};
    case (op_q)
      OP_MUL:                        res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               res = neg_q ? -lo_c[STEP] : lo_c[STEP];
      default:                       res = neg_q ? -hi_c[STEP] : hi_c[STEP];
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = op_in;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            rd_d    = fast_res;
            z_d     = (fast_res == '0);
            state_d = ST_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = a_mag;
            b_d     = b_mag;
            neg_d   = (op_in == OP_REM) ? sa : (sa ^ sb);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        hi_d  = hi_c[STEP];
        lo_d  = lo_c[STEP];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          rd_d    = res;
          z_d     = (res == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          z_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign rd        = rd_q;
  assign z         = z_q;

endmodule
